// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_pkg : types and timing defaults shared across the LCD path     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lcd_pkg;

  localparam int          H_ACTIVE_DEF = 320;
  localparam int          V_ACTIVE_DEF = 255;
  localparam logic [17:0] FILL_RGB_DEF = 18'h3FFFF;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb18_t;

  typedef struct packed {
    logic   sof;
    rgb18_t rgb;
  } fifo_entry_t;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_sync_fifo : single-clock FIFO, first-word-fall-through head     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_sync_fifo #(
  parameter int AW = 9,
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          res,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam logic [AW:0] c_DEPTH = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_level == c_DEPTH);
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign head      = r_mem[r_rptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_pixel_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_pixel_feeder : buffers SOF-tagged RGB18 pixels and emits them  |
// | aligned to delayed hsync/vsync/de. Option macro: LCD_PATTERN_EN    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_pixel_feeder
  import lcd_pkg::*;
#(
  parameter int          FIFO_AW  = 9,
  parameter int          H_ACTIVE = H_ACTIVE_DEF,
  parameter int          V_ACTIVE = V_ACTIVE_DEF,
  parameter logic [17:0] FILL_RGB = FILL_RGB_DEF
) (
  input  logic             clk,
  input  logic             res,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_sof,
  input  logic [17:0]      s_rgb,
  input  logic             hsync_i,
  input  logic             vsync_i,
  input  logic             de_i,
`ifdef LCD_PATTERN_EN
  input  logic             pat_en,
`endif
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [5:0]       r,
  output logic [5:0]       g,
  output logic [5:0]       b,
  output logic             underflow,
  output logic             misalign,
  output logic [FIFO_AW:0] level
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] c_X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] c_Y_LAST = YW'(V_ACTIVE - 1);

  feeder_state_t r_state;
  feeder_state_t w_state_nxt;
  logic          r_vs_prev;
  logic          r_de_prev;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  fifo_entry_t   w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  rgb18_t        w_out;
  logic          w_set_under;
  logic          w_set_mis;
  logic          w_vfall;
  logic          w_de_rise;
  logic          w_at_origin;

  assign w_vfall     = r_vs_prev & ~vsync_i;
  assign w_de_rise   = de_i & ~r_de_prev;
  assign w_at_origin = (r_x == '0) && (r_y == '0);
  assign s_ready     = ~w_full;

  lcd_sync_fifo #(
    .AW (FIFO_AW),
    .DW ($bits(fifo_entry_t))
  ) u_fifo (
    .clk   (clk),
    .res   (res),
    .push  (s_valid),
    .wdata ({s_sof, s_rgb}),
    .pop   (w_pop),
    .head  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

`ifdef LCD_PATTERN_EN
  function automatic rgb18_t pattern_rgb(input logic [YW-1:0] row);
    if (row < YW'(V_ACTIVE / 4))          return rgb18_t'(18'h3F000);
    else if (row < YW'(V_ACTIVE / 2))     return rgb18_t'(18'h00FC0);
    else if (row < YW'(3 * V_ACTIVE / 4)) return rgb18_t'(18'h0003F);
    else                                  return rgb18_t'(18'h3FFFF);
  endfunction
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_set_under = 1'b0;
    w_set_mis   = 1'b0;
    w_out       = FILL_RGB;
`ifdef LCD_PATTERN_EN
    if (pat_en) begin
      w_out = pattern_rgb(r_y);
      if (w_vfall) w_state_nxt = ALIGN;
    end else begin
`else
    begin
`endif
      case (r_state)
        SYNC: begin
          if (w_vfall) w_state_nxt = ALIGN;
        end
        ALIGN: begin
          // Drop stale entries until the head carries the frame start.
          if (!w_vfall) begin
            if (w_de_rise) begin
              w_set_mis   = 1'b1;
              w_state_nxt = SYNC;
            end else if (!w_empty) begin
              if (w_head.sof) w_state_nxt = RUN;
              else            w_pop       = 1'b1;
            end
          end
        end
        RUN: begin
          if (w_vfall) begin
            w_state_nxt = ALIGN;
          end else if (de_i) begin
            if (w_empty) begin
              w_set_under = 1'b1;
            end else if (w_head.sof && !w_at_origin) begin
              w_set_mis   = 1'b1;
              w_state_nxt = SYNC;
            end else begin
              w_pop = 1'b1;
              w_out = w_head.rgb;
              if (!w_head.sof && w_at_origin) w_set_mis = 1'b1;
            end
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) r_state <= SYNC;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_vs_prev <= 1'b1;
      r_de_prev <= 1'b0;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
      de        <= 1'b0;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      underflow <= 1'b0;
      misalign  <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_vs_prev <= vsync_i;
      r_de_prev <= de_i;
      hsync     <= hsync_i;
      vsync     <= vsync_i;
      de        <= de_i;
      if (de_i) {r, g, b} <= w_out;
      if (w_set_under) underflow <= 1'b1;
      if (w_set_mis)   misalign  <= 1'b1;
      if (w_vfall) begin
        r_x <= '0;
        r_y <= '0;
      end else if (de_i) begin
        if (r_x == c_X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == c_Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_pixel_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lcd_pixel_feeder : scoreboard bench against a queue-based model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_lcd_pixel_feeder;

  localparam int          AW    = 9;
  localparam int          H     = 16;
  localparam int          V     = 8;
  localparam int          DEPTH = 512;
  localparam int          NPIX  = H * V;
  localparam logic [17:0] FILL  = 18'h3FFFF;

  localparam int MS_SYNC  = 0;
  localparam int MS_ALIGN = 1;
  localparam int MS_RUN   = 2;

  typedef struct packed {
    logic        sof;
    logic [17:0] rgb;
  } px_t;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic [17:0] s_rgb = '0;
  logic        hsync_i = 1'b1;
  logic        vsync_i = 1'b1;
  logic        de_i = 1'b0;
`ifdef LCD_PATTERN_EN
  logic        pat_en = 1'b0;
`endif
  logic        s_ready;
  logic        hsync, vsync, de, underflow, misalign;
  logic [5:0]  r, g, b;
  logic [AW:0] level;

  always #5 clk = ~clk;

  lcd_pixel_feeder #(
    .FIFO_AW  (AW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .FILL_RGB (FILL)
  ) dut (
    .clk       (clk),
    .res       (res),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_sof     (s_sof),
    .s_rgb     (s_rgb),
    .hsync_i   (hsync_i),
    .vsync_i   (vsync_i),
    .de_i      (de_i),
`ifdef LCD_PATTERN_EN
    .pat_en    (pat_en),
`endif
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .r         (r),
    .g         (g),
    .b         (b),
    .underflow (underflow),
    .misalign  (misalign),
    .level     (level)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel store as a queue, frame position as a linear de count.
  px_t         m_q[$];
  logic [17:0] exp_q[$];
  int          m_mode = MS_SYNC;
  int          m_n = 0;
  bit          m_vs_prev = 1'b1, m_de_prev = 1'b0;
  bit          m_u = 1'b0, m_m = 1'b0;
  bit          m_hs = 1'b1, m_vs = 1'b1, m_de = 1'b0;

  function automatic logic [17:0] pat_rgb(input int row);
    if (row < V / 4)          return 18'h3F000;
    else if (row < V / 2)     return 18'h00FC0;
    else if (row < 3 * V / 4) return 18'h0003F;
    else                      return 18'h3FFFF;
  endfunction

  always @(posedge clk) begin : model
    bit          vfall, derise, hv, pat;
    px_t         head;
    logic [17:0] o;
    int          sz;
    if (res) begin
      m_q.delete();
      exp_q.delete();
      m_mode = MS_SYNC; m_n = 0;
      m_vs_prev = 1'b1; m_de_prev = 1'b0;
      m_u = 1'b0; m_m = 1'b0;
      m_hs = 1'b1; m_vs = 1'b1; m_de = 1'b0;
    end else begin
`ifdef LCD_PATTERN_EN
      pat = pat_en;
`else
      pat = 1'b0;
`endif
      vfall  = m_vs_prev && !vsync_i;
      derise = de_i && !m_de_prev;
      sz     = m_q.size();
      hv     = (sz > 0);
      head   = hv ? m_q[0] : '0;
      o      = FILL;
      if (pat) begin
        o = pat_rgb(m_n / H);
        if (vfall) m_mode = MS_ALIGN;
      end else if (m_mode == MS_SYNC) begin
        if (vfall) m_mode = MS_ALIGN;
      end else if (m_mode == MS_ALIGN) begin
        if (!vfall) begin
          if (derise) begin
            m_m = 1'b1; m_mode = MS_SYNC;
          end else if (hv) begin
            if (head.sof) m_mode = MS_RUN;
            else void'(m_q.pop_front());
          end
        end
      end else begin
        if (vfall) m_mode = MS_ALIGN;
        else if (de_i) begin
          if (!hv) m_u = 1'b1;
          else if (head.sof && m_n != 0) begin
            m_m = 1'b1; m_mode = MS_SYNC;
          end else begin
            o = head.rgb;
            void'(m_q.pop_front());
            if (!head.sof && m_n == 0) m_m = 1'b1;
          end
        end
      end
      if (de_i) exp_q.push_back(o);
      if (s_valid && sz != DEPTH) m_q.push_back({s_sof, s_rgb});
      if (vfall)     m_n = 0;
      else if (de_i) m_n = (m_n + 1) % NPIX;
      m_vs_prev = vsync_i; m_de_prev = de_i;
      m_hs = hsync_i; m_vs = vsync_i; m_de = de_i;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("hsync", hsync, m_hs);
      chk("vsync", vsync, m_vs);
      chk("de", de, m_de);
      chk("level", level, m_q.size());
      chk("s_ready", s_ready, m_q.size() != DEPTH);
      chk("underflow", underflow, m_u);
      chk("misalign", misalign, m_m);
      if (de) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rgb_unexpected: got %05h with no pixel expected", {r, g, b});
        end else begin
          chk("rgb", {14'd0, r, g, b}, {14'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic do_reset();
    res = 1'b1;
    repeat (3) @(negedge clk);
    res = 1'b0;
  endtask

  task automatic push_px(input logic sof, input logic [17:0] rgb);
    s_valid = 1'b1; s_sof = sof; s_rgb = rgb;
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic push_pixels(input int count, input bit first_sof);
    for (int i = 0; i < count; i++) push_px(first_sof && i == 0, 18'($urandom));
  endtask

  task automatic run_frame();
    vsync_i = 1'b0;
    repeat (3) @(negedge clk);
    vsync_i = 1'b1;
    repeat (6) @(negedge clk);
    for (int ln = 0; ln < V; ln++) begin
      hsync_i = 1'b0;
      repeat (2) @(negedge clk);
      hsync_i = 1'b1;
      repeat (3) @(negedge clk);
      de_i = 1'b1;
      repeat (H) @(negedge clk);
      de_i = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    res = 1'b0;
    mon_en = 1'b1;
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_de", de, 0);
    chk("rst_rgb", {r, g, b}, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_level", level, 0);
    chk("rst_s_ready", s_ready, 1);

    // Whole frame queued ahead of the timing.
    push_pixels(NPIX, 1'b1);
    run_frame();
    chk("t1_underflow", underflow, 0);
    chk("t1_misalign", misalign, 0);

    // Junk ahead of the frame start.
    push_pixels(5, 1'b0);
    push_pixels(NPIX, 1'b1);
    run_frame();
    chk("t2_misalign", misalign, 0);
    chk("t2_level", level, 0);

    // Producer stalls mid-line 3.
    push_pixels(3 * H + 5, 1'b1);
    fork
      run_frame();
      begin
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
          if (m_n >= 3 * H + 15) begin ok = 1'b1; break; end
          @(negedge clk);
        end
        if (!ok) begin
          errors++;
          $display("FAIL t3_wait: stall point not reached, got n=%0d expected %0d", m_n, 3 * H + 15);
        end
        push_pixels(NPIX - (3 * H + 5), 1'b0);
      end
    join
    chk("t3_underflow", underflow, 1);

    // Early SOF at (5,2), followed by a full frame from that SOF.
    push_pixels(2 * H + 5, 1'b1);
    push_pixels(NPIX, 1'b1);
    run_frame();
    chk("t4_misalign", misalign, 1);
    run_frame();
    chk("t4_level", level, 0);

    // Fill to capacity with no display activity.
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) push_px(1'b0, 18'($urandom));
    chk("t5_level_full", level, DEPTH);
    chk("t5_s_ready_full", s_ready, 0);
    vsync_i = 1'b0;
    @(negedge clk);
    vsync_i = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (level != DEPTH) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      errors++;
      $display("FAIL t5_first_pop: level stuck, got %0d expected %0d", level, DEPTH - 1);
    end
    chk("t5_s_ready_after_pop", s_ready, 1);
    chk("t5_level_after_pop", level, DEPTH - 1);
    repeat (DEPTH + 8) @(negedge clk);
    chk("t5_drained", level, 0);

`ifdef LCD_PATTERN_EN
    do_reset();
    pat_en = 1'b1;
    run_frame();
    pat_en = 1'b0;
    chk("t6_underflow", underflow, 0);
`endif

    repeat (4) @(negedge clk);
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
